// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: processor writeback has priority, debounced button
// changes fill idle slots, and a starvation guard forces an I/O slot. Define SWITCH_MIRROR_EN
// to add the slide-switch mirror as a fifth I/O source.
`timescale 1ns/1ps
module regfile_wport_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned STARVE_LIMIT    = 8,
   parameter logic [4:0]  BTN_BASE_REG    = 5'd1,
   parameter logic [4:0]  SW_REG          = 5'd5
) (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        proc_we,
   input  logic [4:0]  proc_waddr,
   input  logic [31:0] proc_wdata,
   output logic        proc_stall,
   output logic        proc_wr_blocked,
   input  logic        btn_UP,
   input  logic        btn_DOWN,
   input  logic        btn_LEFT,
   input  logic        btn_RIGHT,
   input  logic [15:0] switch,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic [4:0]  io_pending
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT - 1);
   localparam logic [4:0] BTN_REG_1 = BTN_BASE_REG + 5'd1;
   localparam logic [4:0] BTN_REG_2 = BTN_BASE_REG + 5'd2;
   localparam logic [4:0] BTN_REG_3 = BTN_BASE_REG + 5'd3;
`ifdef SWITCH_MIRROR_EN
   localparam int unsigned N_SRC_I = 5;
`else
   localparam int unsigned N_SRC_I = 4;
`endif
   localparam logic [3:0] N_SRC = 4'(N_SRC_I);

   typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

   logic [3:0]       meta_q, meta_d, sync_q, sync_d, stable_q, stable_d, val_q, val_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [4:0]       pend_q, pend_d, accept, grant_vec;
   logic [2:0]       rr_q, rr_d, grant_idx;
   logic [3:0]       scan_sum;
   logic [STV_W-1:0] starve_q, starve_d;
   state_t           state_q, state_d;
   logic             reserved, proc_grant, io_avail, io_grant;
`ifdef SWITCH_MIRROR_EN
   logic [15:0]      sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d, sw_cap_q, sw_cap_d;
`else
   logic             unused_sw;
   assign unused_sw = ^{switch, SW_REG};
`endif

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin : debounce_comb
      meta_d   = {btn_RIGHT, btn_LEFT, btn_DOWN, btn_UP};
      sync_d   = meta_q;
      stable_d = stable_q;
      val_d    = val_q;
      accept   = '0;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = sync_q[i];
            val_d[i]    = sync_q[i];
            cnt_d[i]    = '0;
            accept[i]   = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
`ifdef SWITCH_MIRROR_EN
      sw_meta_d = switch;
      sw_sync_d = sw_meta_q;
      sw_cap_d  = sw_cap_q;
      if (sw_sync_q != sw_cap_q) begin
         sw_cap_d  = sw_sync_q;
         accept[4] = 1'b1;
      end
`endif
   end

`ifdef SWITCH_MIRROR_EN
   assign reserved = (proc_waddr == 5'd0) || (proc_waddr == BTN_BASE_REG) || (proc_waddr == BTN_REG_1) ||
                     (proc_waddr == BTN_REG_2) || (proc_waddr == BTN_REG_3) || (proc_waddr == SW_REG);
`else
   assign reserved = (proc_waddr == 5'd0) || (proc_waddr == BTN_BASE_REG) || (proc_waddr == BTN_REG_1) ||
                     (proc_waddr == BTN_REG_2) || (proc_waddr == BTN_REG_3);
`endif
   assign proc_stall      = (state_q == ST_FORCE);
   assign proc_wr_blocked = proc_we && reserved;
   assign proc_grant      = proc_we && !proc_stall && !proc_wr_blocked;
   assign io_grant        = io_avail && !proc_grant;
   assign grant_vec       = io_grant ? (5'b00001 << grant_idx) : 5'b00000;
   assign io_pending      = pend_q;

   // Round-robin scan: first pending source at or after rr_q, wrapping modulo N_SRC.
   always_comb begin : grant_comb
      io_avail  = 1'b0;
      grant_idx = '0;
      scan_sum  = '0;
      for (int k = 0; k < N_SRC_I; k++) begin
         scan_sum = {1'b0, rr_q} + 4'(k);
         if (scan_sum >= N_SRC) scan_sum = scan_sum - N_SRC;
         if (!io_avail && pend_q[scan_sum[2:0]]) begin
            io_avail  = 1'b1;
            grant_idx = scan_sum[2:0];
         end
      end
   end

   always_comb begin : port_mux_comb
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      pend_d           = accept | (pend_q & ~grant_vec);
      rr_d             = rr_q;
      if (proc_grant) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = proc_waddr;
         data_writeReg    = proc_wdata;
      end else if (io_avail) begin
         ctrl_writeEnable = 1'b1;
         rr_d = ({1'b0, grant_idx} == N_SRC - 4'd1) ? 3'd0 : grant_idx + 3'd1;
`ifdef SWITCH_MIRROR_EN
         if (grant_idx == 3'd4) begin
            ctrl_writeReg = SW_REG;
            data_writeReg = {16'b0, sw_cap_q};
         end else
`endif
         begin
            ctrl_writeReg = BTN_BASE_REG + {3'b000, grant_idx[1:0]};
            data_writeReg = {31'b0, val_q[grant_idx[1:0]]};
         end
      end
   end

   always_comb begin : fsm_comb
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         ST_NORMAL: begin
            if (|pend_q && proc_grant) begin
               if (starve_q == STV_MAX) begin
                  state_d  = ST_FORCE;
                  starve_d = '0;
               end else begin
                  starve_d = starve_q + 1'b1;
               end
            end else begin
               starve_d = '0;
            end
         end
         default: begin
            state_d  = ST_NORMAL;
            starve_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         meta_q   <= '0;
         sync_q   <= '0;
         stable_q <= '0;
         val_q    <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         pend_q   <= '0;
         rr_q     <= '0;
         starve_q <= '0;
         state_q  <= ST_NORMAL;
`ifdef SWITCH_MIRROR_EN
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         sw_cap_q  <= '0;
`endif
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         stable_q <= stable_d;
         val_q    <= val_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         rr_q     <= rr_d;
         starve_q <= starve_d;
         state_q  <= state_d;
`ifdef SWITCH_MIRROR_EN
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
         sw_cap_q  <= sw_cap_d;
`endif
      end
   end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Owns the single register-file write port and shares it between the processor writeback stage and the board I/O (four buttons, optionally the switches).
- Synchronises and debounces the buttons. Queues each debounced change as a pending write to its I/O register, and inserts these writes into cycles the processor leaves free.
- A starvation guard stalls processor writeback for one cycle when I/O writes wait too long.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a button change (>=2).
- STARVE_LIMIT, 8, consecutive cycles with I/O pending but the port granted to the processor before a forced I/O slot (>=1).
- BTN_BASE_REG, 1, register index for btn_UP; DOWN/LEFT/RIGHT use BTN_BASE_REG+1..+3.
- SW_REG, 5, register index for the switch mirror (used only with SWITCH_MIRROR_EN).

Ports:
- clock  in  1  system clock, all state on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- proc_we  in  1  processor writeback request
- proc_waddr  in  5  processor destination register
- proc_wdata  in  32  processor write data
- proc_stall  out  1  processor must hold writeback this cycle
- proc_wr_blocked  out  1  current processor write dropped (reserved destination)
- btn_UP, btn_DOWN, btn_LEFT, btn_RIGHT  in  1 each  raw asynchronous buttons
- switch  in  16  raw slide switches
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  5  regfile write address
- data_writeReg  out  32  regfile write data
- io_pending  out  5  per-source pending flags; bits 0-3 are the buttons, bit 4 is the switch mirror

Behaviour:
- Clock, reset and synchronisation
  - One clock, named clock. Reset is ctrl_reset, synchronous and active-high.
  - Reset clears all synchronisers, debounce counters, stable values, pending flags, the round-robin pointer, the starvation counter and the FSM (to NORMAL).
  - Reset is sampled every edge and wins over every other update, including mid-debounce, mid-pending and during FORCE.
- Synchroniser: two flops per button.
- Debounce (per button i, on each edge)
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter++.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0, pending[i] <= 1, val[i] <= sync.
  - Raw change to accepted pending: 2 + DEBOUNCE_CYCLES edges.
- Pending flags
  - A new acceptance while pending[i]=1 overwrites val[i]; the flag stays set (newest value wins).
  - If acceptance and grant of the same source coincide, set wins and val updates.
  - A granted source clears its pending flag at the grant edge.
- Reserved destinations: processor writes to reg 0, or to any I/O-owned register (BTN_BASE_REG..+3, plus SW_REG when enabled), are dropped. proc_wr_blocked=1 in that cycle (combinational), and the slot is free for I/O.
- Write-port mux (combinational from current state)
  - 1) proc_we && !proc_stall && !blocked: ctrl_writeEnable=1, ctrl_writeReg=proc_waddr, data_writeReg=proc_wdata.
  - 2) Otherwise, if any pending: grant the first pending source at or after the rr pointer. Outputs: ctrl_writeEnable=1, address of that source, data {31'b0,val} for a button or {16'b0,sw} for the switch mirror. rr <= granted+1 mod N.
  - 3) Otherwise ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- FSM
  - NORMAL: starve counter increments on each edge where any pending && processor granted; it clears when pending is none or an I/O grant occurs. When counter == STARVE_LIMIT-1 and the increment condition holds: go to FORCE, counter <= 0.
  - FORCE: proc_stall=1 (registered, exactly one cycle); an I/O grant is guaranteed. Next state NORMAL. If pending emptied before FORCE, the cycle is idle.
- Output reset values: proc_stall=0, io_pending=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, proc_wr_blocked=0 while proc_we=0.
- Processor contract: it must hold proc_we/waddr/wdata while proc_stall=1.

Optional Feature:
- Macro: SWITCH_MIRROR_EN.
- Defined:
  - The switches get two-flop synchronisation; there is no debounce.
  - Any change of the synchronised 16-bit word versus its last captured value sets pending[4] and captures the word.
  - Round robin spans 5 sources, and SW_REG is reserved.
- Undefined: there are 4 sources, io_pending[4] is tied 0, switch is unused, and SW_REG is writable by the processor.

Test Plan:
- Reset, then hold btn_UP=1 from cycle 0 with proc_we=0 → io_pending[0]=1 after 18 edges; next cycle ctrl_writeEnable=1, ctrl_writeReg=1, data_writeReg=1; io_pending[0]=0 after that.
- Glitch btn_LEFT high for 5 cycles → no pending, no write; the debounce counter returns to 0.
- Pending UP and RIGHT, proc_we=1 every cycle to reg 9 → processor granted 8 cycles; proc_stall=1 on the 9th with a write to reg 1; 8 more processor cycles; then a stall with a write to reg 4.
- proc_we=1, proc_waddr=3, with UP pending → proc_wr_blocked=1, the port writes reg 1 with 1, reg 3 is untouched. proc_waddr=0 → blocked, no write.
- All four buttons accepted on the same edge, idle processor → writes to regs 1,2,3,4 in consecutive cycles. Assert ctrl_reset during the second of them → next cycle all pending=0 and writeEnable=0.
- With SWITCH_MIRROR_EN, switch=16'hA5A5 → a write to reg 5 of 32'h0000A5A5 within 4 cycles. Without the macro, no write, and a processor write to reg 5 passes through.
